// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: steps each instruction through
// fetch/decode/execute/memory/write-back, one state per clock.
module multicycle_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        WBMEM  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        WBR    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } stateT;

    localparam logic [5:0] opRType = 6'b000000;
    localparam logic [5:0] opLw    = 6'b100011;
    localparam logic [5:0] opSw    = 6'b101011;
    localparam logic [5:0] opBeq   = 6'b000100;
    localparam logic [5:0] opJ     = 6'b000010;

    stateT state;
    stateT nextState;
    logic  illegalOp;
    logic  isIllegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegalOp <= 1'b0;
        end else if (isIllegal) begin
            illegalOp <= 1'b1;
        end
    end

    // Memory handshake: a request (MemRead/MemWrite) stays asserted every
    // cycle until MemReady is seen high; that cycle completes the access and
    // only then does the FSM advance. MemReady is ignored outside FETCH/MEMRD/MEMWR.
    always_comb begin
        nextState   = FETCH;
        isIllegal   = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDest     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        InstrDone   = 1'b0;
        case (state)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                nextState = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    opRType:     nextState = EXEC;
                    opLw, opSw:  nextState = MEMADR;
                    opBeq:       nextState = BRANCH;
                    opJ:         nextState = JUMP;
                    default: begin
                        nextState = FETCH;
                        isIllegal = 1'b1;
                        InstrDone = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = (opcode == opLw) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nextState = MemReady ? WBMEM : MEMRD;
            end
            WBMEM: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
                nextState = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nextState = WBR;
            end
            WBR: begin
                RegWrite  = 1'b1;
                RegDest   = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                InstrDone   = 1'b1;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
            end
            default: nextState = FETCH;
        endcase

        // Outputs are forced quiet while reset is held, even though FETCH requests a read.
        if (!reset_n) begin
            isIllegal   = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemToReg    = 1'b0;
            RegDest     = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            InstrDone   = 1'b0;
        end
    end

    assign State     = state;
    assign IllegalOp = illegalOp;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams compared against a per-instruction state-path model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDest, RegWrite, ALUSrcA, InstrDone, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int   checks = 0;
    int   failures = 0;
    logic expIllegal = 1'b0;

    localparam logic [5:0] opRType = 6'b000000;
    localparam logic [5:0] opLw    = 6'b100011;
    localparam logic [5:0] opSw    = 6'b101011;
    localparam logic [5:0] opBeq   = 6'b000100;
    localparam logic [5:0] opJ     = 6'b000010;

    multicycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDest(RegDest), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
        .State(State)
    );

    always #5 clk = ~clk;

    logic [16:0] obsOut;
    assign obsOut = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemToReg, RegDest, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, InstrDone};

    function automatic bit isLegal(logic [5:0] op);
        return op == opRType || op == opLw || op == opSw || op == opBeq || op == opJ;
    endfunction

    // Expected control word, stated one output at a time from the state it is active in.
    function automatic logic [16:0] expOutputs(int s, bit mr, bit illegalDecode);
        logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
        logic       memToReg, regDest, regWrite, aluSrcA, instrDone;
        logic [1:0] aluSrcB, aluOp, pcSource;
        pcWrite     = (s == 0 && mr) || s == 9;
        pcWriteCond = (s == 8);
        iorD        = (s == 3 || s == 5);
        memRead     = (s == 0 || s == 3);
        memWrite    = (s == 5);
        irWrite     = (s == 0 && mr);
        memToReg    = (s == 4);
        regDest     = (s == 7);
        regWrite    = (s == 4 || s == 7);
        aluSrcA     = (s == 2 || s == 6 || s == 8);
        aluSrcB     = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2) ? 2'b10 : 2'b00;
        aluOp       = (s == 6) ? 2'b10 : (s == 8) ? 2'b01 : 2'b00;
        pcSource    = (s == 8) ? 2'b01 : (s == 9) ? 2'b10 : 2'b00;
        instrDone   = s == 4 || s == 7 || s == 8 || s == 9 ||
                      (s == 5 && mr) || (s == 1 && illegalDecode);
        return {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                regDest, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns later.
    task automatic stepCycle(string tag, int s, bit mr, logic [5:0] op);
        bit illegalDecode;
        illegalDecode = (s == 1) && !isLegal(op);
        @(negedge clk);
        opcode   = op;
        MemReady = mr;
        #1;
        check({tag, " state"}, 32'(State), 32'(s));
        check({tag, " outputs"}, 32'(obsOut), 32'(expOutputs(s, mr, illegalDecode)));
        check({tag, " illegal"}, 32'(IllegalOp), 32'(expIllegal));
        if (illegalDecode) expIllegal = 1'b1;
    endtask

    task automatic checkQuiet(string tag);
        check({tag, " outputs"}, 32'(obsOut), 32'd0);
        check({tag, " state"}, 32'(State), 32'd0);
        check({tag, " illegal"}, 32'(IllegalOp), 32'd0);
    endtask

    // Builds the expected state path for one instruction, then runs it.
    task automatic runInstr(string tag, logic [5:0] op, int fetchStall, int memStall);
        int expStateQ[$];
        bit mrQ[$];
        repeat (fetchStall) begin expStateQ.push_back(0); mrQ.push_back(1'b0); end
        expStateQ.push_back(0); mrQ.push_back(1'b1);
        expStateQ.push_back(1); mrQ.push_back(1'($urandom_range(0, 1)));
        if (op == opRType) begin
            expStateQ.push_back(6); mrQ.push_back(1'($urandom_range(0, 1)));
            expStateQ.push_back(7); mrQ.push_back(1'($urandom_range(0, 1)));
        end else if (op == opLw || op == opSw) begin
            expStateQ.push_back(2); mrQ.push_back(1'($urandom_range(0, 1)));
            repeat (memStall) begin expStateQ.push_back(op == opLw ? 3 : 5); mrQ.push_back(1'b0); end
            expStateQ.push_back(op == opLw ? 3 : 5); mrQ.push_back(1'b1);
            if (op == opLw) begin
                expStateQ.push_back(4); mrQ.push_back(1'($urandom_range(0, 1)));
            end
        end else if (op == opBeq) begin
            expStateQ.push_back(8); mrQ.push_back(1'($urandom_range(0, 1)));
        end else if (op == opJ) begin
            expStateQ.push_back(9); mrQ.push_back(1'($urandom_range(0, 1)));
        end
        while (expStateQ.size() > 0) begin
            int  s;
            bit  mr;
            s  = expStateQ.pop_front();
            mr = mrQ.pop_front();
            stepCycle(tag, s, mr, (s == 0) ? 6'($urandom) : op);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        opcode   = 6'd0;
        MemReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkQuiet("reset held");
        @(posedge clk); #2 reset_n = 1'b1;
        stepCycle("fetch after release", 0, 1'b0, 6'd0);
        reset_n = 1'b0;
        #1;
        checkQuiet("async reset in fetch");
        @(posedge clk); #2 reset_n = 1'b1;

        runInstr("rtype", opRType, 0, 0);
        runInstr("lw stall2", opLw, 0, 2);
        runInstr("sw", opSw, 0, 0);
        runInstr("beq", opBeq, 0, 0);
        runInstr("j fetchstall3", opJ, 3, 0);
        runInstr("illegal 3f", 6'h3F, 0, 0);
        repeat (3) runInstr("rtype sticky", opRType, 0, 0);

        stepCycle("abort fetch", 0, 1'b1, 6'd0);
        stepCycle("abort decode", 1, 1'b0, opSw);
        stepCycle("abort memadr", 2, 1'b1, opSw);
        stepCycle("abort memwr", 5, 1'b0, opSw);
        reset_n = 1'b0;
        #1;
        checkQuiet("async reset in memwr");
        expIllegal = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        runInstr("rtype after abort", opRType, 1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 5))
                0: op = opRType;
                1: op = opLw;
                2: op = opSw;
                3: op = opBeq;
                4: op = opJ;
                default: begin
                    op = 6'($urandom);
                    while (isLegal(op)) op = 6'($urandom);
                end
            endcase
            runInstr("random", op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
